// File: rtl/exu_dispatch_queue_pkg.sv
// Shared definitions for the execute dispatch queue: group codes, default sizes
// and dispatch payload field offsets.
package exu_dispatch_queue_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int NUM_CH_DEF    = 6;
    localparam int GRP_W_DEF     = 3;
    localparam int PAYLOAD_W_DEF = 128;

    // Channel index equals the decode group code.
    typedef enum logic [GRP_W_DEF-1:0] {
        GRP_ALU    = 3'd0,
        GRP_BJP    = 3'd1,
        GRP_MULDIV = 3'd2,
        GRP_CSR    = 3'd3,
        GRP_MEM    = 3'd4,
        GRP_SYS    = 3'd5
    } grp_e;

    localparam int PL_RS1_LSB = 0;
    localparam int PL_RS2_LSB = 32;
    localparam int PL_PC_LSB  = 64;
    localparam int PL_OP_LSB  = 96;

    function automatic int entry_width(input int grp_w, input int payload_w);
        return grp_w + 1 + payload_w;
    endfunction

endpackage

// File: rtl/exu_dispatch_queue_if.sv
// Decode-side and functional-unit-side signals of the dispatch queue.
interface exu_dispatch_queue_if #(
    parameter int DEPTH     = 4,
    parameter int NUM_CH    = 6,
    parameter int GRP_W     = 3,
    parameter int PAYLOAD_W = 128
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [GRP_W-1:0]     in_grp;
    logic                 in_fence;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    ch_busy;
    logic [PAYLOAD_W-1:0] ch_payload;
    logic [CNT_W-1:0]     count;
    logic                 illegal;

    modport master (
        output flush, in_valid, in_grp, in_fence, in_payload, ch_ready, ch_busy,
        input  in_ready, ch_valid, ch_payload, count, illegal
    );

    modport slave (
        input  flush, in_valid, in_grp, in_fence, in_payload, ch_ready, ch_busy,
        output in_ready, ch_valid, ch_payload, count, illegal
    );
endinterface

// File: rtl/exu_dispatch_fifo.sv
// Circular buffer with wrap-bit pointers, asynchronous head read and flush.
module exu_dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 132
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok, pop_ok;

    assign empty   = (head_reg == tail_reg);
    assign full    = (head_reg[AW-1:0] == tail_reg[AW-1:0]) && (head_reg[AW] != tail_reg[AW]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_reg[head_reg[AW-1:0]];
    assign count   = count_reg;

    // Storage is kept free of reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem_reg[tail_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop_ok) begin
                head_reg <= head_reg + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end
endmodule

// File: rtl/exu_dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions and issues the head (or a
// bypassed incoming instruction) to one functional-unit channel per cycle.
module exu_dispatch_queue
    import exu_dispatch_queue_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int GRP_W     = GRP_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    exu_dispatch_queue_if.slave  bus
);
    localparam int ENT_W = entry_width(GRP_W, PAYLOAD_W);

    logic [ENT_W-1:0]     in_ent, head_ent;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [GRP_W-1:0]     cand_grp;
    logic                 cand_fence;
    logic [PAYLOAD_W-1:0] cand_payload;
    logic                 cand_valid, cand_active, cand_legal, fence_ok;
    logic                 issue, fire, illegal_drop, consume;
    logic [NUM_CH-1:0]    ch_valid_c;

    assign in_ent = {bus.in_grp, bus.in_fence, bus.in_payload};

    // An empty queue presents the incoming instruction as the candidate (bypass).
    assign {cand_grp, cand_fence, cand_payload} = fifo_empty ? in_ent : head_ent;

    assign cand_valid   = !fifo_empty || bus.in_valid;
    assign cand_active  = cand_valid && !bus.flush && !rst;
    assign cand_legal   = int'(cand_grp) < NUM_CH;
    assign fence_ok     = !cand_fence || (bus.ch_busy == '0);
    assign issue        = cand_active && cand_legal && fence_ok;
    assign illegal_drop = cand_active && !cand_legal;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_valid_c[gi] = issue && (cand_grp == GRP_W'(gi));
        end
    endgenerate

    assign fire    = |(ch_valid_c & bus.ch_ready);
    assign consume = fire || illegal_drop;

    // in_ready deliberately ignores ch_ready so no path runs from the units back to decode.
    assign bus.in_ready   = !rst && !fifo_full && !bus.flush;
    assign fifo_pop       = !fifo_empty && consume;
    assign fifo_push      = bus.in_valid && bus.in_ready && !(fifo_empty && consume);
    assign bus.ch_valid   = ch_valid_c;
    assign bus.ch_payload = cand_payload;
    assign bus.illegal    = illegal_drop;

    exu_dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_ent),
        .rdata (head_ent),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.count)
    );
endmodule
